// File: rtl/rv32_mdu_iter_if.sv
// Request/response bundle between the EX stage and the iterative RV32M unit.
// The master drives the operation; the slave (the MDU) returns status and result.
interface rv32_mdu_iter_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, rs1, rs2, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, op, rs1, rs2, flush,
      output busy, done, result
   );
endinterface

// File: rtl/rv32_mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with a sign-fix cycle and a registered result.
module rv32_mdu_iter #(
   parameter int XLEN     = 32,
   parameter int FAST_MUL = 0
) (
   input logic            clk,
   input logic            rst_n,
   rv32_mdu_iter_if.slave mdu
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   mag;
   logic [2:0]        op_q;
   logic              a_neg_q;
   logic              b_neg_q;
   logic              busy_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   assign mdu.busy   = busy_q;
   assign mdu.done   = done_q;
   assign mdu.result = result_q;

   // Operand decode at acceptance: which operands are signed for this funct3.
   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div_zero, div_ovf;

   always_comb begin
      a_sgn    = (mdu.op == 3'b001) || (mdu.op == 3'b010) || (mdu.op[2] && !mdu.op[0]);
      b_sgn    = (mdu.op == 3'b001) || (mdu.op[2] && !mdu.op[0]);
      a_neg    = a_sgn && mdu.rs1[XLEN-1];
      b_neg    = b_sgn && mdu.rs2[XLEN-1];
      a_abs    = a_neg ? -mdu.rs1 : mdu.rs1;
      b_abs    = b_neg ? -mdu.rs2 : mdu.rs2;
      div_zero = mdu.op[2] && (mdu.rs2 == '0);
      div_ovf  = mdu.op[2] && !mdu.op[0] && (mdu.rs1 == SMIN) && (mdu.rs2 == '1);
   end

   // Single-cycle multiply path; tied off when only the iterative path is wanted.
   logic [XLEN-1:0] fast_res;
   generate
      if (FAST_MUL != 0) begin : g_fast
         logic [2*XLEN-1:0] fast_mag, fast_prod;
         assign fast_mag  = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
         assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
         assign fast_res  = (mdu.op[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                   : fast_prod[2*XLEN-1:XLEN];
      end else begin : g_no_fast
         assign fast_res = '0;
      end
   endgenerate

   // One iteration step. Multiply keeps {partial, multiplier} and shifts right;
   // divide keeps {remainder, dividend/quotient} and shifts left.
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] acc_step;

   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
      div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, mag};
      if (!op_q[2])
         acc_step = {mul_sum, acc[XLEN-1:1]};
      else if (!div_diff[XLEN])
         acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_step = {acc[2*XLEN-2:0], 1'b0};
   end

   // Sign fix and half select for the FIX cycle.
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   always_comb begin
      prod_s = (a_neg_q ^ b_neg_q) ? -acc : acc;
      quo_s  = (a_neg_q ^ b_neg_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_s  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (op_q[2])
         fix_res = op_q[1] ? rem_s : quo_s;
      else
         fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mag      <= '0;
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else if (mdu.flush) begin
         // Abort wins over everything, including a coincident start.
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (mdu.start) begin
                  op_q    <= mdu.op;
                  a_neg_q <= a_neg;
                  b_neg_q <= b_neg;
                  cnt     <= CW'(XLEN-1);
                  if (div_zero) begin
                     result_q <= mdu.op[1] ? mdu.rs1 : '1;
                     state    <= DONE;
                     done_q   <= 1'b1;
                  end else if (div_ovf) begin
                     result_q <= mdu.op[1] ? '0 : mdu.rs1;
                     state    <= DONE;
                     done_q   <= 1'b1;
                  end else if (FAST_MUL != 0 && !mdu.op[2]) begin
                     result_q <= fast_res;
                     state    <= DONE;
                     done_q   <= 1'b1;
                  end else begin
                     acc    <= {{XLEN{1'b0}}, (mdu.op[2] ? a_abs : b_abs)};
                     mag    <= mdu.op[2] ? b_abs : a_abs;
                     state  <= CALC;
                     busy_q <= 1'b1;
                  end
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt - 1'b1;
               if (cnt == '0)
                  state <= FIX;
            end
            FIX: begin
               result_q <= fix_res;
               state    <= DONE;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rv32_mdu_iter.sv
// Directed bench for rv32_mdu_iter (XLEN=32, iterative multiply).
module tb_rv32_mdu_iter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   rv32_mdu_iter_if #(.XLEN(32)) mif();

   rv32_mdu_iter #(.XLEN(32), .FAST_MUL(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mdu   (mif.slave)
   );

   // Issue one op, scramble operands after acceptance, wait for done.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      @(negedge clk);
      mif.op = o; mif.rs1 = a; mif.rs2 = b; mif.start = 1'b1;
      @(posedge clk);
      #1 mif.start = 1'b0; mif.rs1 = $urandom; mif.rs2 = $urandom;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (mif.busy) bcnt++;
         if (mif.done) begin lat = i; break; end
      end
      res = mif.result;
      checks++;
      if (lat == 0) begin errs++; $display("FAIL timeout op=%0d: no done within 100 cycles", o); end
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({mif.busy, mif.done, mif.result} !== 34'd0) begin
         errs++; $display("FAIL reset_state got busy=%b done=%b result=%h exp 0/0/0", mif.busy, mif.done, mif.result);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_mul;
      logic [31:0] r; int lat, bc;
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mul_result got %h exp ffffffeb", r); end
      checks++; if (lat !== 34) begin errs++; $display("FAIL mul_latency got %0d exp 34", lat); end
      checks++; if (bc !== 33) begin errs++; $display("FAIL mul_busy_cycles got %0d exp 33", bc); end
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
      checks++; if (r !== 32'h4000_0000) begin errs++; $display("FAIL mulh got %h exp 40000000", r); end
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFFE) begin errs++; $display("FAIL mulhu got %h exp fffffffe", r); end
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mulhsu got %h exp ffffffff", r); end
      run_op(3'b001, 32'hFFFF_FFF9, 32'd3, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mulh_neg got %h exp ffffffff", r); end
   endtask

   task automatic test_div_special;
      logic [31:0] r; int lat, bc;
      run_op(3'b100, 32'h1234_5678, 32'd0, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div0_result got %h exp ffffffff", r); end
      checks++; if (lat !== 1) begin errs++; $display("FAIL div0_latency got %0d exp 1", lat); end
      checks++; if (bc !== 0) begin errs++; $display("FAIL div0_busy got %0d exp 0", bc); end
      run_op(3'b111, 32'h1234_5678, 32'd0, r, lat, bc);
      checks++; if (r !== 32'h1234_5678) begin errs++; $display("FAIL remu0 got %h exp 12345678", r); end
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
      checks++; if (r !== 32'h8000_0000) begin errs++; $display("FAIL div_ovf got %h exp 80000000", r); end
      checks++; if (lat !== 1) begin errs++; $display("FAIL div_ovf_latency got %0d exp 1", lat); end
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
      checks++; if (r !== 32'h0) begin errs++; $display("FAIL rem_ovf got %h exp 00000000", r); end
   endtask

   task automatic test_div;
      logic [31:0] r; int lat, bc;
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rem_neg got %h exp ffffffff", r); end
      checks++; if (lat !== 34) begin errs++; $display("FAIL rem_latency got %0d exp 34", lat); end
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
      checks++; if (r !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_neg got %h exp fffffffd", r); end
      run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
      checks++; if (r !== 32'd14) begin errs++; $display("FAIL divu got %h exp 0000000e", r); end
   endtask

   // Relies on the previous result being 14 (DIVU 100/7).
   task automatic test_flush;
      int dn = 0;
      @(negedge clk);
      mif.op = 3'b101; mif.rs1 = 32'd200; mif.rs2 = 32'd3; mif.start = 1'b1;
      @(posedge clk); #1 mif.start = 1'b0;
      repeat (10) @(negedge clk);
      mif.flush = 1'b1;
      @(posedge clk); #1 mif.flush = 1'b0;
      @(negedge clk);
      checks++; if (mif.busy !== 1'b0) begin errs++; $display("FAIL flush_busy got %b exp 0", mif.busy); end
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (mif.done) dn++; end
      checks++; if (dn !== 0) begin errs++; $display("FAIL flush_no_done got %0d pulses exp 0", dn); end
      checks++; if (mif.result !== 32'd14) begin errs++; $display("FAIL flush_result got %h exp 0000000e", mif.result); end
      mif.start = 1'b1; mif.flush = 1'b1;
      @(posedge clk); #1 mif.start = 1'b0; mif.flush = 1'b0;
      dn = 0;
      @(negedge clk);
      checks++; if (mif.busy !== 1'b0) begin errs++; $display("FAIL start_flush_busy got %b exp 0", mif.busy); end
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (mif.done) dn++; end
      checks++; if (dn !== 0) begin errs++; $display("FAIL start_flush_done got %0d pulses exp 0", dn); end
   endtask

   task automatic test_start_ignored;
      int lat = 0;
      @(negedge clk);
      mif.op = 3'b101; mif.rs1 = 32'd1000; mif.rs2 = 32'd10; mif.start = 1'b1;
      @(posedge clk); #1 mif.start = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 5) begin mif.op = 3'b000; mif.rs1 = 32'd3; mif.rs2 = 32'd5; mif.start = 1'b1; end
         if (i == 6) mif.start = 1'b0;
         if (mif.done) begin lat = i; break; end
      end
      checks++; if (lat !== 34) begin errs++; $display("FAIL ignore_latency got %0d exp 34", lat); end
      checks++; if (mif.result !== 32'd100) begin errs++; $display("FAIL ignore_result got %h exp 00000064", mif.result); end
      // Start raised in the DONE cycle must not be taken.
      mif.op = 3'b101; mif.rs1 = 32'd9; mif.rs2 = 32'd3; mif.start = 1'b1;
      @(posedge clk); #1 mif.start = 1'b0;
      @(negedge clk);
      checks++; if (mif.busy !== 1'b0) begin errs++; $display("FAIL done_start_busy got %b exp 0", mif.busy); end
      repeat (3) @(negedge clk);
      checks++; if (mif.busy !== 1'b0 || mif.result !== 32'd100) begin
         errs++; $display("FAIL done_start_ignored got busy=%b result=%h exp 0/00000064", mif.busy, mif.result);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      mif.op = 3'b000; mif.rs1 = 32'd11; mif.rs2 = 32'd13; mif.start = 1'b1;
      @(posedge clk); #1 mif.start = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (mif.busy !== 1'b1) begin errs++; $display("FAIL mid_busy got %b exp 1", mif.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({mif.busy, mif.done, mif.result} !== 34'd0) begin
         errs++; $display("FAIL mid_reset got busy=%b done=%b result=%h exp 0/0/0", mif.busy, mif.done, mif.result);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
         errs++; $display("FAIL post_reset got busy=%b done=%b exp 0/0", mif.busy, mif.done);
      end
   endtask

   initial begin
      mif.start = 1'b0; mif.flush = 1'b0; mif.op = '0; mif.rs1 = '0; mif.rs2 = '0;
      test_reset();
      test_mul();
      test_div_special();
      test_div();
      test_flush();
      test_start_ignored();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
